// File: rtl/id_decode_stage.sv
// RV32I decode stage: register file, instruction decode, load-use stall.
// Drives the ID/EX register inputs; the register file is written from WB.
module id_decode_stage #(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr_in,
   input  logic            instr_valid,
   input  logic            wb_wen,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [4:0]      ex_rd,
   input  logic            ex_load,
   output logic [XLEN-1:0] data_1_out,
   output logic [XLEN-1:0] data_2_out,
   output logic [4:0]      Rd_out,
   output logic [3:0]      ALU_ctrl_out,
   output logic            ALU_src_out,
   output logic [XLEN-1:0] imm_out,
   output logic            MEM_wen_out,
   output logic            WB_sel_out,
   output logic            stall_out,
   output logic            illegal_out
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_e;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_LUI = 7'b0110111;

   logic [XLEN-1:0] rf [NREGS];

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd_fld;

   assign opcode = instr_in[6:0];
   assign funct3 = instr_in[14:12];
   assign funct7 = instr_in[31:25];
   assign rs1    = instr_in[19:15];
   assign rs2    = instr_in[24:20];
   assign rd_fld = instr_in[11:7];

   logic is_op;
   logic is_imm;
   logic is_lw;
   logic is_sw;
   logic is_lui;

   assign is_op  = (opcode == OPC_OP);
   assign is_imm = (opcode == OPC_IMM);
   assign is_lw  = (opcode == OPC_LW);
   assign is_sw  = (opcode == OPC_SW);
   assign is_lui = (opcode == OPC_LUI);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_wen && wb_rd != 5'd0) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // WB write-through so a value written this cycle is seen by decode now
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0) begin
         rs1_val = (wb_wen && wb_rd == rs1) ? wb_data : rf[rs1];
      end
      if (rs2 != 5'd0) begin
         rs2_val = (wb_wen && wb_rd == rs2) ? wb_data : rf[rs2];
      end
   end

   logic            legal;
   logic            use1;
   logic            use2;
   alu_e            alu;
   logic            src;
   logic [XLEN-1:0] imm;
   logic [4:0]      rd;
   logic            mwen;
   logic            wbsel;
   alu_e            f3_alu;

   always_comb begin
      f3_alu = ALU_ADD;
      case (funct3)
         3'b000:  f3_alu = ALU_ADD;
         3'b001:  f3_alu = ALU_SLL;
         3'b010:  f3_alu = ALU_SLT;
         3'b011:  f3_alu = ALU_SLTU;
         3'b100:  f3_alu = ALU_XOR;
         3'b101:  f3_alu = instr_in[30] ? ALU_SRA : ALU_SRL;
         3'b110:  f3_alu = ALU_OR;
         default: f3_alu = ALU_AND;
      endcase
   end

   always_comb begin
      legal = 1'b0;
      use1  = 1'b0;
      use2  = 1'b0;
      alu   = ALU_ADD;
      src   = 1'b0;
      imm   = '0;
      rd    = '0;
      mwen  = 1'b0;
      wbsel = 1'b0;
      unique case (1'b1)
         is_op: begin
            legal = (funct7 == 7'h00) ||
                    (funct7 == 7'h20 &&
                     (funct3 == 3'b000 || funct3 == 3'b101));
            use1  = 1'b1;
            use2  = 1'b1;
            rd    = rd_fld;
            alu   = f3_alu;
            if (funct7[5] && funct3 == 3'b000) alu = ALU_SUB;
         end
         is_imm: begin
            use1 = 1'b1;
            src  = 1'b1;
            rd   = rd_fld;
            alu  = f3_alu;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               legal = (funct7 == 7'h00) ||
                       (funct7 == 7'h20 && funct3 == 3'b101);
               imm   = {27'd0, instr_in[24:20]};
            end else begin
               legal = 1'b1;
               imm   = {{20{instr_in[31]}}, instr_in[31:20]};
            end
         end
         is_lw: begin
            legal = (funct3 == 3'b010);
            use1  = 1'b1;
            src   = 1'b1;
            rd    = rd_fld;
            wbsel = 1'b1;
            imm   = {{20{instr_in[31]}}, instr_in[31:20]};
         end
         is_sw: begin
            legal = (funct3 == 3'b010);
            use1  = 1'b1;
            use2  = 1'b1;
            src   = 1'b1;
            mwen  = 1'b1;
            imm   = {{20{instr_in[31]}}, funct7, rd_fld};
         end
         is_lui: begin
            legal = 1'b1;
            src   = 1'b1;
            rd    = rd_fld;
            imm   = {instr_in[31:12], 12'd0};
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   logic hazard;
   logic emit;

   // Only sources the instruction actually reads can cause a load-use stall
   assign hazard = ex_load && ex_rd != 5'd0 &&
                   ((use1 && ex_rd == rs1) ||
                    (use2 && ex_rd == rs2));

   assign emit      = reset && instr_valid && legal && !hazard;
   assign stall_out = reset && instr_valid && legal && hazard;

   assign data_1_out   = (emit && !is_lui) ? rs1_val : '0;
   assign data_2_out   = (emit && use2) ? rs2_val : '0;
   assign Rd_out       = emit ? rd : 5'd0;
   assign ALU_ctrl_out = emit ? alu : 4'd0;
   assign ALU_src_out  = emit && src;
   assign imm_out      = emit ? imm : '0;
   assign MEM_wen_out  = emit && mwen;
   assign WB_sel_out   = emit && wbsel;

   logic illegal_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_q <= 1'b0;
      end else if (instr_valid && !legal) begin
         illegal_q <= 1'b1;
      end
   end

   assign illegal_out = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed plan steps then random stimulus
// checked against a behavioural decode model with its own register array.
module tb_id_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  ex_rd;
   logic        ex_load;
   logic [31:0] data_1_out;
   logic [31:0] data_2_out;
   logic [4:0]  Rd_out;
   logic [3:0]  ALU_ctrl_out;
   logic        ALU_src_out;
   logic [31:0] imm_out;
   logic        MEM_wen_out;
   logic        WB_sel_out;
   logic        stall_out;
   logic        illegal_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs [32];
   logic        ill;

   always #5 clk = ~clk;

   id_decode_stage dut (
      .clk          (clk),
      .reset        (reset),
      .instr_in     (instr_in),
      .instr_valid  (instr_valid),
      .wb_wen       (wb_wen),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .ex_rd        (ex_rd),
      .ex_load      (ex_load),
      .data_1_out   (data_1_out),
      .data_2_out   (data_2_out),
      .Rd_out       (Rd_out),
      .ALU_ctrl_out (ALU_ctrl_out),
      .ALU_src_out  (ALU_src_out),
      .imm_out      (imm_out),
      .MEM_wen_out  (MEM_wen_out),
      .WB_sel_out   (WB_sel_out),
      .stall_out    (stall_out),
      .illegal_out  (illegal_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] reg_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_wen && wb_rd == r) return wb_data;
      return regs[r];
   endfunction

   function automatic logic is_legal(input logic [31:0] ins);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      case (op)
         7'h33: return f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
         7'h13: begin
            if (f3 == 1) return f7 == 0;
            if (f3 == 5) return f7 == 0 || f7 == 7'h20;
            return 1'b1;
         end
         7'h03:   return f3 == 3'd2;
         7'h23:   return f3 == 3'd2;
         7'h37:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_all(input string tag);
      int          rtab [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
      logic [31:0] ins;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] e_d1, e_d2, e_imm;
      logic [4:0]  e_rd;
      logic [3:0]  e_alu;
      logic        e_src, e_mw, e_wb, e_st, e_il, lg, u1, u2;
      bit          chk_d2;
      ins = instr_in;
      op = ins[6:0];
      f3 = ins[14:12];
      e_d1 = 0; e_d2 = 0; e_imm = 0; e_rd = 0; e_alu = 0;
      e_src = 0; e_mw = 0; e_wb = 0; e_st = 0; e_il = 0;
      chk_d2 = 1;
      if (reset) begin
         e_il = ill;
         lg = is_legal(ins);
         u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23};
         u2 = op inside {7'h33, 7'h23};
         e_st = instr_valid && lg && ex_load && ex_rd != 0 &&
                ((u1 && ex_rd == ins[19:15]) ||
                 (u2 && ex_rd == ins[24:20]));
         if (instr_valid && lg && !e_st) begin
            e_rd  = (op == 7'h23) ? 5'd0 : ins[11:7];
            e_d1  = (op == 7'h37) ? 32'd0 : reg_read(ins[19:15]);
            chk_d2 = u2;
            if (u2) e_d2 = reg_read(ins[24:20]);
            e_src = (op != 7'h33);
            e_mw  = (op == 7'h23);
            e_wb  = (op == 7'h03);
            case (op)
               7'h33: begin
                  if (ins[30]) e_alu = (f3 == 0) ? 4'd1 : 4'd7;
                  else e_alu = 4'(rtab[f3]);
               end
               7'h13: begin
                  e_alu = (f3 == 5 && ins[30]) ? 4'd7 : 4'(rtab[f3]);
                  if (f3 == 1 || f3 == 5) e_imm = 32'(ins[24:20]);
                  else e_imm = 32'($signed(ins[31:20]));
               end
               7'h03: e_imm = 32'($signed(ins[31:20]));
               7'h23: e_imm = 32'($signed({ins[31:25], ins[11:7]}));
               default: e_imm = ins & 32'hFFFF_F000;
            endcase
         end
      end
      chk({tag, ".data_1"}, data_1_out, e_d1);
      if (chk_d2) chk({tag, ".data_2"}, data_2_out, e_d2);
      chk({tag, ".rd"}, 32'(Rd_out), 32'(e_rd));
      chk({tag, ".alu"}, 32'(ALU_ctrl_out), 32'(e_alu));
      chk({tag, ".alu_src"}, 32'(ALU_src_out), 32'(e_src));
      chk({tag, ".imm"}, imm_out, e_imm);
      chk({tag, ".mem_wen"}, 32'(MEM_wen_out), 32'(e_mw));
      chk({tag, ".wb_sel"}, 32'(WB_sel_out), 32'(e_wb));
      chk({tag, ".stall"}, 32'(stall_out), 32'(e_st));
      chk({tag, ".illegal"}, 32'(illegal_out), 32'(e_il));
   endtask

   task automatic drive(input string tag, input logic [31:0] ins,
                        input logic v, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] erd, input logic el);
      @(negedge clk);
      instr_in = ins;
      instr_valid = v;
      wb_wen = we;
      wb_rd = wr;
      wb_data = wd;
      ex_rd = erd;
      ex_load = el;
      #1;
      check_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         if (wb_wen && wb_rd != 0) regs[wb_rd] = wb_data;
         if (instr_valid && !is_legal(instr_in)) ill = 1'b1;
      end
      #1;
   endtask

   task automatic assert_reset();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      ill = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  r1, r2, rd;
      logic [2:0]  f3;
      logic [11:0] im;
      logic [6:0]  f7;
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      f3 = 3'($urandom);
      im = 12'($urandom);
      case ($urandom_range(0, 5))
         0: begin
            f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (f7 == 7'h20 && f3 != 0 && f3 != 5) f3 = 3'd0;
            return {f7, r2, r1, f3, rd, 7'h33};
         end
         1: begin
            if (f3 == 1) im[11:5] = 7'h00;
            if (f3 == 5) im[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            return {im, r1, f3, rd, 7'h13};
         end
         2: return {im, r1, 3'd2, rd, 7'h03};
         3: return {im[11:5], r2, r1, 3'd2, im[4:0], 7'h23};
         4: return {20'($urandom), rd, 7'h37};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      ill = 1'b0;
      assert_reset();
      instr_in = 32'h0050_0093;
      instr_valid = 1'b1;
      wb_wen = 1'b1;
      wb_rd = 5'd3;
      wb_data = 32'h1234_5678;
      ex_rd = 5'd0;
      ex_load = 1'b0;
      #2;
      check_all("reset");
      chk("reset.imm0", imm_out, 32'd0);
      tick();
      tick();
      check_all("reset_held");
      @(negedge clk);
      reset = 1'b1;

      drive("addi", 32'h0050_0093, 1, 0, 0, 0, 0, 0);
      chk("addi.imm", imm_out, 32'd5);
      chk("addi.src", 32'(ALU_src_out), 32'd1);
      chk("addi.rd", 32'(Rd_out), 32'd1);
      chk("addi.alu", 32'(ALU_ctrl_out), 32'd0);
      tick();

      drive("wt", 32'h0001_01B3, 1, 1, 5'd2, 32'hDEAD_BEEF, 0, 0);
      chk("wt.bypass", data_1_out, 32'hDEAD_BEEF);
      tick();
      drive("wt_st", 32'h0001_01B3, 1, 0, 0, 0, 0, 0);
      chk("wt.stored", data_1_out, 32'hDEAD_BEEF);
      tick();
      drive("x0w", 32'h0000_0033, 1, 1, 5'd0, 32'h0000_0123, 0, 0);
      chk("x0.bypass", data_1_out, 32'd0);
      tick();
      drive("x0r", 32'h0000_0033, 1, 0, 0, 0, 0, 0);
      chk("x0.read", data_1_out, 32'd0);
      tick();

      drive("w5", 32'h0, 0, 1, 5'd5, 32'h11, 0, 0);
      tick();
      drive("w6", 32'h0, 0, 1, 5'd6, 32'h100, 0, 0);
      tick();
      drive("sw", 32'hFE53_2E23, 1, 0, 0, 0, 0, 0);
      chk("sw.mem_wen", 32'(MEM_wen_out), 32'd1);
      chk("sw.rd", 32'(Rd_out), 32'd0);
      chk("sw.imm", imm_out, 32'hFFFF_FFFC);
      chk("sw.d1", data_1_out, 32'h100);
      chk("sw.d2", data_2_out, 32'h11);
      tick();

      drive("lu_stall", 32'h0013_8433, 1, 0, 0, 0, 5'd7, 1);
      chk("lu.stall", 32'(stall_out), 32'd1);
      chk("lu.bubble_rd", 32'(Rd_out), 32'd0);
      tick();
      drive("lu_go", 32'h0013_8433, 1, 0, 0, 0, 5'd7, 0);
      chk("lu.nostall", 32'(stall_out), 32'd0);
      chk("lu.rd", 32'(Rd_out), 32'd8);
      tick();
      drive("lu_x0", 32'h0013_8433, 1, 0, 0, 0, 5'd0, 1);
      chk("lu_x0.stall", 32'(stall_out), 32'd0);
      tick();
      drive("lu_lui", 32'h1234_53B7, 1, 0, 0, 0, 5'd7, 1);
      chk("lu_lui.stall", 32'(stall_out), 32'd0);
      chk("lu_lui.rd", 32'(Rd_out), 32'd7);
      tick();

      drive("midstall", 32'h0013_8433, 1, 0, 0, 0, 5'd7, 1);
      chk("midstall.stall", 32'(stall_out), 32'd1);
      #1;
      assert_reset();
      #1;
      chk("midstall.rst_stall", 32'(stall_out), 32'd0);
      check_all("midstall_rst");
      tick();
      @(negedge clk);
      reset = 1'b1;

      drive("ill", 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
      chk("ill.rd", 32'(Rd_out), 32'd0);
      chk("ill.flag_pre", 32'(illegal_out), 32'd0);
      tick();
      drive("ill_post", 32'h0050_0093, 1, 0, 0, 0, 0, 0);
      chk("ill.flag", 32'(illegal_out), 32'd1);
      tick();
      drive("ill_stick", 32'h0050_0093, 1, 0, 0, 0, 0, 0);
      chk("ill.sticky", 32'(illegal_out), 32'd1);
      tick();
      @(negedge clk);
      assert_reset();
      #1;
      chk("ill.cleared", 32'(illegal_out), 32'd0);
      tick();
      @(negedge clk);
      reset = 1'b1;

      drive("w2", 32'h0, 0, 1, 5'd2, 32'h8000_0040, 0, 0);
      tick();
      drive("srai", 32'h4031_5093, 1, 0, 0, 0, 0, 0);
      chk("srai.alu", 32'(ALU_ctrl_out), 32'd7);
      chk("srai.imm", imm_out, 32'd3);
      tick();
      drive("lui", 32'h1234_5237, 1, 0, 0, 0, 0, 0);
      chk("lui.imm", imm_out, 32'h1234_5000);
      chk("lui.d1", data_1_out, 32'd0);
      tick();

      for (int n = 0; n < 400; n++) begin
         drive("rnd", rand_instr(), ($urandom_range(0, 9) != 0),
               1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 1'($urandom));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Decode-stage producer for the ID/EX pipeline register: it decodes the IF/ID instruction and supplies data_1, data_2, Rd, ALU_ctrl, ALU_src, imm, MEM_wen and WB_sel.
- Owns the 32x32 integer register file, with its write port driven from WB.
- Detects load-use hazards against the instruction currently in EX, inserting a bubble and stalling fetch.
- Holds a sticky illegal-instruction flag.
- Supported RV32I subset: OP, OP-IMM, LW, SW, LUI.

Parameters:
NREGS, 32, register count; x0 hardwired to zero
XLEN, 32, datapath width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
instr_in  in  32  instruction from IF/ID
instr_valid  in  1  instr_in holds a real instruction
wb_wen  in  1  register-file write enable from WB
wb_rd  in  5  WB destination register
wb_data  in  32  WB write data
ex_rd  in  5  Rd currently held in ID/EX (Rd_out of that stage)
ex_load  in  1  WB_sel currently held in ID/EX (1 = load in EX)
data_1_out  out  32  rs1 operand (0 for LUI)
data_2_out  out  32  rs2 operand (store data for SW)
Rd_out  out  5  destination register (0 for SW and bubbles)
ALU_ctrl_out  out  4  ALU operation
ALU_src_out  out  1  1 = ALU B operand is imm
imm_out  out  32  sign-extended or U-type immediate
MEM_wen_out  out  1  store enable
WB_sel_out  out  1  0 = ALU result, 1 = load data
stall_out  out  1  hold PC and IF/ID this cycle
illegal_out  out  1  sticky: an unsupported opcode was decoded

Behaviour:
Reset:
- While reset=0: all register-file entries are 0, illegal_out=0, and every output is forced to 0, including stall_out.
- Reset takes effect immediately and asynchronously, including mid-stall.

Register file:
- Written on posedge clk when wb_wen=1 and wb_rd!=0.
- Writes to x0 are ignored; reads of x0 return 0.
- Reads are combinational with write-through: if wb_wen=1, wb_rd!=0 and wb_rd equals rs1 (or rs2), the corresponding operand is wb_data in the same cycle.

ALU_ctrl encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Codes 10-15 are never emitted.

Decode, by opcode (instr[6:0]):
- 0110011 OP: funct3/funct7[5] select ALU_ctrl; ALU_src=0; Rd=instr[11:7]; WB_sel=0; MEM_wen=0.
- 0010011 OP-IMM: imm = sext(instr[31:20]); ALU_src=1.
  - SRAI selected by instr[30].
  - Shift imm is the zero-extended shamt instr[24:20].
  - No SUBI: funct3=000 is always ADD.
- 0000011 LW (funct3=010): ADD, ALU_src=1, I-imm, WB_sel=1, Rd=instr[11:7].
- 0100011 SW (funct3=010): ADD, ALU_src=1, S-imm = sext({instr[31:25],instr[11:7]}), MEM_wen=1, Rd=0.
- 0110111 LUI: data_1=0, imm = {instr[31:12],12'b0}, ADD, ALU_src=1, Rd=instr[11:7].

Bubble:
- Bubble = all outputs 0 except stall_out.
- Emitted when instr_valid=0, or opcode/funct is unsupported, or a load-use stall is active.

Illegal flag:
- Set on the posedge after an unsupported instruction is decoded with instr_valid=1.
- Cleared only by reset.

Load-use hazard:
- stall_out=1 iff instr_valid=1, ex_load=1, ex_rd!=0, and ex_rd equals a source the instruction actually uses:
  - rs1: OP, OP-IMM, LW, SW
  - rs2: OP, SW
- During a stall the outputs are a bubble.
- The next cycle, ex_load=0 (the bubble is now in EX), so stall_out drops and the held instruction decodes normally.
- Stall lasts exactly 1 cycle per hazard.
- No forwarding from EX/MEM is done here beyond the WB write-through.

Latency and widths:
- Decode is combinational; the ID/EX register provides the pipeline stage.
- Register file write to read-visible: same cycle via bypass; stored value from the next cycle on.
- All immediates sign-extend from bit 31 except U-type and shamt.

Test Plan:
1. Reset: hold reset=0 with instr_in=0x00500093 and instr_valid=1 -> all outputs 0; release -> ADDI x1,x0,5 gives imm_out=5, ALU_src_out=1, Rd_out=1, ALU_ctrl_out=0.
2. Write-through: wb_wen=1, wb_rd=2, wb_data=0xDEADBEEF while decoding ADD x3,x2,x0 (0x000101B3) -> data_1_out=0xDEADBEEF the same cycle. A write to x0 followed by reading x0 -> 0.
3. SW x5,-4(x6) (0xFE532E23) with x5=0x11, x6=0x100 -> MEM_wen_out=1, Rd_out=0, imm_out=0xFFFFFFFC, data_1_out=0x100, data_2_out=0x11.
4. Load-use: ex_load=1, ex_rd=7, decode ADD x8,x7,x1 -> stall_out=1 and bubble; next cycle ex_load=0 -> normal decode, Rd_out=8.
   - Same with ex_rd=0 -> no stall.
   - LUI x7 with ex_rd=7 -> no stall.
5. Decoding 0xFFFFFFFF with instr_valid=1 -> bubble, illegal_out=1 from the next edge and staying 1 through later valid instructions; reset=0 clears it.
6. SRAI x1,x2,3 (0x40315093) -> ALU_ctrl_out=7, imm_out=3. LUI x4,0x12345 -> imm_out=0x12345000, data_1_out=0.
